// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with a bounded grant hold.
// Grant, valid and preempt are registered and feed a one-hot-to-binary encoder.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic           preempt_q, preempt_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     win_q, win_d;
    logic [7:0]     cnt_q, cnt_d;

    logic [N-1:0]   winOh;
    logic [N-1:0]   others;
    logic [3:0]     pickReq;
    logic [3:0]     pickOthers;

    // Returns {found, index}; scanning downward lets the lowest offset from ptr win.
    function automatic logic [3:0] pick(input logic [N-1:0] mask, input logic [2:0] ptr);
        logic [2:0] idx;
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (mask[idx]) pick = {1'b1, idx};
        end
    endfunction

    assign winOh      = N'(1) << win_q;
    assign others     = req & ~winOh;
    assign pickReq    = pick(req, ptr_q);
    assign pickOthers = pick(others, ptr_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pickReq[3]) begin
                    win_d   = pickReq[2:0];
                    grant_d = N'(1) << pickReq[2:0];
                    ptr_d   = pickReq[2:0] + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[win_q]) begin
                    if (cnt_q < HOLD_LAST) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        // Timeout: hand over only if someone else is waiting.
                        cnt_d = 8'd0;
                        if (pickOthers[3]) begin
                            win_d     = pickOthers[2:0];
                            grant_d   = N'(1) << pickOthers[2:0];
                            ptr_d     = pickOthers[2:0] + 3'd1;
                            preempt_d = 1'b1;
                        end
                    end
                end else if (pickReq[3]) begin
                    win_d   = pickReq[2:0];
                    grant_d = N'(1) << pickReq[2:0];
                    ptr_d   = pickReq[2:0] + 3'd1;
                    cnt_d   = 8'd0;
                end else begin
                    grant_d = '0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= 3'd0;
            win_q     <= 3'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: one instance at HOLD_MAX=15, one at HOLD_MAX=1.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req1;
    logic [7:0] grant, grant1;
    logic       grantValid, grantValid1;
    logic       preempt, preempt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N(8), .HOLD_MAX(15)) dut (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant), .grant_valid(grantValid), .preempt(preempt)
    );

    rr_grant_arbiter #(.N(8), .HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1),
        .grant(grant1), .grant_valid(grantValid1), .preempt(preempt1)
    );

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic [7:0] rq1);
        rst  = r;
        req  = rq;
        req1 = rq1;
        @(posedge clk);
        #2;
    endtask

    // Compares one instance's outputs and its per-cycle invariants.
    task automatic checkOutput(input string tag, input logic [7:0] g, input logic v, input logic p,
                               input logic [7:0] expG, input logic expP);
        vectors++;
        assert (g === expG) else begin
            miscompares++;
            $error("[TB] FAIL %s grant got %h want %h", tag, g, expG);
        end
        vectors++;
        assert (v === (|expG)) else begin
            miscompares++;
            $error("[TB] FAIL %s grant_valid got %b want %b", tag, v, |expG);
        end
        vectors++;
        assert (p === expP) else begin
            miscompares++;
            $error("[TB] FAIL %s preempt got %b want %b", tag, p, expP);
        end
        vectors++;
        assert ($onehot0(g) && (v === (|g))) else begin
            miscompares++;
            $error("[TB] FAIL %s invariant grant %h valid %b", tag, g, v);
        end
    endtask

    task automatic applyReset();
        applyStimulus(1'b1, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] expRot;
        rst  = 1'b1;
        req  = 8'h00;
        req1 = 8'h00;

        $display("[TB] reset and idle");
        applyReset();
        checkOutput("reset", grant, grantValid, preempt, 8'h00, 1'b0);
        checkOutput("reset1", grant1, grantValid1, preempt1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00);
            checkOutput("idle", grant, grantValid, preempt, 8'h00, 1'b0);
        end

        $display("[TB] first grant and release handoff");
        applyStimulus(1'b0, 8'h24, 8'h00);
        checkOutput("first24", grant, grantValid, preempt, 8'h04, 1'b0);
        applyStimulus(1'b0, 8'h20, 8'h00);
        checkOutput("handoff20", grant, grantValid, preempt, 8'h20, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("release", grant, grantValid, preempt, 8'h00, 1'b0);

        $display("[TB] HOLD_MAX=1 rotation");
        applyReset();
        applyStimulus(1'b0, 8'h00, 8'hFF);
        checkOutput("rot0", grant1, grantValid1, preempt1, 8'h01, 1'b0);
        expRot = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            expRot = {expRot[6:0], expRot[7]};
            applyStimulus(1'b0, 8'h00, 8'hFF);
            checkOutput("rot", grant1, grantValid1, preempt1, expRot, 1'b1);
        end

        $display("[TB] HOLD_MAX=15 timeout between 0 and 7");
        applyReset();
        applyStimulus(1'b0, 8'h81, 8'h00);
        checkOutput("hold01", grant, grantValid, preempt, 8'h01, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 8'h81, 8'h00);
            checkOutput("hold01", grant, grantValid, preempt, 8'h01, 1'b0);
        end
        applyStimulus(1'b0, 8'h81, 8'h00);
        checkOutput("preempt80", grant, grantValid, preempt, 8'h80, 1'b1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 8'h81, 8'h00);
            checkOutput("hold80", grant, grantValid, preempt, 8'h80, 1'b0);
        end
        applyStimulus(1'b0, 8'h81, 8'h00);
        checkOutput("back01", grant, grantValid, preempt, 8'h01, 1'b1);

        $display("[TB] lone requester keeps grant past timeout");
        applyReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 8'h08, 8'h00);
            checkOutput("lone08", grant, grantValid, preempt, 8'h08, 1'b0);
        end

        $display("[TB] winner releases at timeout cycle");
        applyReset();
        applyStimulus(1'b0, 8'h03, 8'h00);
        checkOutput("rel01", grant, grantValid, preempt, 8'h01, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 8'h03, 8'h00);
        end
        checkOutput("rel01end", grant, grantValid, preempt, 8'h01, 1'b0);
        applyStimulus(1'b0, 8'h02, 8'h00);
        checkOutput("rel02", grant, grantValid, preempt, 8'h02, 1'b0);

        $display("[TB] reset mid-grant");
        applyReset();
        applyStimulus(1'b0, 8'h10, 8'h00);
        checkOutput("grant10", grant, grantValid, preempt, 8'h10, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("midreset", grant, grantValid, preempt, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        checkOutput("postreset", grant, grantValid, preempt, 8'h01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter for 8 request lines. Produces the registered one-hot grant vector and valid flag that feed the downstream 8-to-3 one-hot encoder.
- grant drives the encoder data input. grant_valid drives the encoder enable, so the encoder sees either a legal one-hot code or is disabled.
- Grants are held while the winner keeps requesting, bounded by a hold limit to prevent starvation.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the 3-bit encoder.
- HOLD_MAX, 15, maximum consecutive cycles one requester may hold a grant while others are waiting; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector, bit i = requester i; any pattern legal
- grant  output  8  registered grant; all-zero or exactly one bit set
- grant_valid  output  1  registered; equals OR of grant; drives encoder enable
- preempt  output  1  one-cycle pulse when a grant is withdrawn by hold timeout

Behaviour:
- Reset (rst=1 at a rising edge):
  - grant=8'h00, grant_valid=0, preempt=0.
  - Round-robin pointer ptr=0, hold counter=0, state IDLE.
  - Reset wins over all other events. Reset mid-grant clears grant at that edge, with no preempt pulse.
- Arbitration function pick(mask):
  - Returns the first set bit of mask scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8 wrap).
  - Returns none if mask=0.
- States:
  - IDLE: grant=0.
    - If req!=0, then at the next edge grant <= onehot(pick(req)), ptr <= winner+1 mod 8, hold counter <= 0, state GRANT.
    - Request-to-grant latency is 1 cycle.
  - GRANT, winner w:
    - req[w]=1 and hold counter < HOLD_MAX-1: keep grant; counter increments.
    - req[w]=0, with no timeout that cycle: if req!=0, re-arbitrate immediately. At the next edge grant switches to onehot(pick(req)) with no idle gap; ptr updates; counter <= 0. If req=0, grant <= 0 and state IDLE.
    - req[w]=1 and counter = HOLD_MAX-1 (timeout):
      - Others waiting (req with bit w cleared is non-zero): next grant = pick(req & ~onehot(w)); ptr updates; counter <= 0; preempt=1 for that one cycle.
      - Nobody else waiting: w keeps the grant, counter <= 0, no preempt.
- Counter width: 8 bits; never exceeds HOLD_MAX-1.
- Pointer wrap: winner 7 gives ptr=0.
- Invariants, checked every cycle after reset:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - grant only changes on a clock edge.
  - No requester waits more than 8*HOLD_MAX cycles while continuously requesting.
- Requests dropping or rising in the same cycle as a timeout use the sampled req of that cycle. A winner whose req falls at timeout is treated as the normal release path, with no preempt.
- HOLD_MAX=1: every grant lasts 1 cycle while others request, giving pure round-robin rotation.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant=00, grant_valid=0, preempt=0 throughout.
- From reset (ptr=0), req=8'h24 held -> 1 cycle later grant=8'h04 (encoder out 3'b010). Drop req[2] -> next cycle grant=8'h20, no gap.
- req=8'hFF, HOLD_MAX=1 -> grant sequence 01,02,04,...,80,01 (wrap), one per cycle, preempt high every cycle after the first grant.
- HOLD_MAX=15, req=8'h81 held continuously -> grant=8'h01 for 15 cycles, then preempt pulse and grant=8'h80 for 15 cycles, then back to 8'h01.
- Only req[3] held for 40 cycles -> grant=8'h08 continuously, preempt never asserts.
- grant=8'h10 active, assert rst for 1 cycle with req=8'hFF -> next edge grant=00, grant_valid=0. Release rst -> grant=8'h01 (ptr reset to 0).
